// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory loader.
// Holds the loader FSM state encoding, the default geometry and a small
// helper for sizing the loader's byte counter.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_WIDTH = 13;
    localparam int unsigned IMEM_DATA_WIDTH = 32;
    localparam int unsigned IMEM_LEN_BYTES  = 4;

    typedef enum logic [2:0] {
        IMEM_IDLE = 3'd0,
        IMEM_LEN  = 3'd1,
        IMEM_DATA = 3'd2,
        IMEM_DONE = 3'd3,
        IMEM_ERR  = 3'd4
    } imem_state_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned imem_cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/imem_ram_sp.sv
// Single-port inferred block RAM.
// Ports:
//   clk  - clock, rising edge
//   we   - write enable (qualified by en)
//   en   - port enable; dout only updates when en is high
//   addr - word address
//   din  - write data
//   dout - registered read data, 1-cycle latency, write-first
// Contents are not reset.
module imem_ram_sp #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout      <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream program loader and a fetch port.
// A load is a little-endian word-count header of LEN_BYTES bytes followed
// by that many little-endian DATA_WIDTH-bit words, written from address 0.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   load_start          - pulse: start (or restart) a program load
//   rx_valid/rx_data    - incoming byte stream
//   rx_ready            - byte accepted when rx_valid && rx_ready
//   load_busy           - a load is in progress (LEN/DATA/DONE/ERR)
//   load_done           - one-cycle pulse on successful completion
//   load_err            - sticky: header length exceeded the memory depth
//   word_count          - words written by the current or last load
//   fetch_en/fetch_addr - processor read request, byte address
//   fetch_data          - read data, holds when no fetch completes
//   fetch_valid         - fetch_data answers the previous cycle's request
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int unsigned LEN_BYTES  = IMEM_LEN_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count,
    input  logic                  fetch_en,
    input  logic [31:0]           fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LEN_W = 8 * LEN_BYTES;
    localparam int unsigned MAXB  = (LEN_BYTES > BYTES) ? LEN_BYTES : BYTES;
    localparam int unsigned CNT_W = imem_cnt_width(MAXB);

    imem_state_t state, state_next;

    logic [CNT_W-1:0]      byte_cnt;
    logic [LEN_W-1:0]      len_reg;
    logic [DATA_WIDTH-1:0] word_reg;

    logic                  rx_fire;
    logic                  last_len_byte;
    logic                  last_data_byte;
    logic [LEN_W-1:0]      len_full;
    logic [DATA_WIDTH-1:0] word_full;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   wc_inc;

    logic                  fetch_req;
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] fetch_hold;
    logic                  unused_addr_bits;

    // Bytes shift in from the top, so after the final byte the first one
    // received sits in bits [7:0] (little-endian) with no indexed writes.
    assign len_full  = {rx_data, len_reg[LEN_W-1:8]};
    assign word_full = {rx_data, word_reg[DATA_WIDTH-1:8]};

    assign rx_fire        = rx_valid && rx_ready;
    assign last_len_byte  = (byte_cnt == CNT_W'(LEN_BYTES - 1));
    assign last_data_byte = (byte_cnt == CNT_W'(BYTES - 1));
    assign wr_en          = (state == IMEM_DATA) && rx_fire && last_data_byte;
    assign wc_inc         = word_count + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IMEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load_start restarts from any state.
    always_comb begin
        state_next = state;
        unique case (state)
            IMEM_IDLE: ;
            IMEM_LEN: begin
                if (rx_fire && last_len_byte) begin
                    if (len_full == '0) begin
                        state_next = IMEM_DONE;
                    end else if (64'(len_full) > 64'(DEPTH)) begin
                        state_next = IMEM_ERR;
                    end else begin
                        state_next = IMEM_DATA;
                    end
                end
            end
            IMEM_DATA: begin
                if (wr_en && (64'(wc_inc) == 64'(len_reg))) begin
                    state_next = IMEM_DONE;
                end
            end
            IMEM_DONE: state_next = IMEM_IDLE;
            IMEM_ERR:  state_next = IMEM_IDLE;
            default:   state_next = IMEM_IDLE;
        endcase
        if (load_start) begin
            state_next = IMEM_LEN;
        end
    end

    // Outputs decoded from state
    always_comb begin
        rx_ready  = 1'b0;
        load_busy = 1'b1;
        load_done = 1'b0;
        unique case (state)
            IMEM_IDLE: load_busy = 1'b0;
            IMEM_LEN:  rx_ready  = 1'b1;
            IMEM_DATA: rx_ready  = 1'b1;
            IMEM_DONE: load_done = 1'b1;
            IMEM_ERR:  ;
            default:   load_busy = 1'b0;
        endcase
    end

    // Byte assembler, counters and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            len_reg    <= '0;
            word_reg   <= '0;
            word_count <= '0;
            load_err   <= 1'b0;
        end else if (load_start) begin
            byte_cnt   <= '0;
            len_reg    <= '0;
            word_count <= '0;
            load_err   <= 1'b0;
        end else begin
            if (rx_fire && (state == IMEM_LEN)) begin
                len_reg  <= len_full;
                byte_cnt <= last_len_byte ? '0 : byte_cnt + CNT_W'(1);
            end
            if (rx_fire && (state == IMEM_DATA)) begin
                word_reg <= word_full;
                byte_cnt <= last_data_byte ? '0 : byte_cnt + CNT_W'(1);
            end
            if (wr_en) begin
                word_count <= wc_inc;
            end
            if ((state == IMEM_LEN) && (state_next == IMEM_ERR)) begin
                load_err <= 1'b1;
            end
        end
    end

    // Port arbitration: writes only happen while busy, and fetches are
    // blocked while busy, so the loader always owns the port during a load.
    assign fetch_req = fetch_en && !load_busy;
    assign ram_en    = wr_en || fetch_req;
    assign ram_addr  = wr_en ? word_count[ADDR_WIDTH-1:0]
                             : fetch_addr[ADDR_WIDTH+1:2];

    assign unused_addr_bits = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0]};

    imem_ram_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .en   (ram_en),
        .addr (ram_addr),
        .din  (word_full),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_req;
        end
    end

    // RAM dout also moves on loader writes (write-first), so the last
    // fetched word is kept separately to hold fetch_data across stalls
    // and loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_hold <= '0;
        end else if (fetch_valid) begin
            fetch_hold <= ram_dout;
        end
    end

    assign fetch_data = fetch_valid ? ram_dout : fetch_hold;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2**AW;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;
    logic          fetch_en;
    logic [31:0]   fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;

    instr_mem_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_BYTES  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_count  (word_count),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; bit check; } fexp_t;
    typedef struct { bit err; logic [AW:0] wc; } lexp_t;
    typedef struct { string name; logic [63:0] act; logic [63:0] req; } chk_t;

    fexp_t fq[$];
    lexp_t lq[$];
    chk_t  cq[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit err_prev = 1'b0;
    bit end_req = 1'b0;
    bit end_ack = 1'b0;

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        chk_t  c;
        fexp_t f;
        lexp_t l;
        while (cq.size() > 0) begin
            c = cq.pop_front();
            n_cmp++;
            if (c.act !== c.req) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.req);
            end
        end
        if (!rst) begin
            if (fetch_valid) begin
                n_cmp++;
                if (fq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_fetch_valid: got 1, expected 0");
                end else begin
                    f = fq.pop_front();
                    if (f.check && (fetch_data !== f.data)) begin
                        n_bad++;
                        $display("FAIL fetch_data: got %08h, expected %08h", fetch_data, f.data);
                    end
                end
            end
            if (load_done || (load_err && !err_prev)) begin
                n_cmp++;
                if (lq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_load_event: done=%0b err=%0b", load_done, load_err);
                end else begin
                    l = lq.pop_front();
                    if ((l.err !== !load_done) || (l.wc !== word_count)) begin
                        n_bad++;
                        $display("FAIL load_event: got err=%0b wc=%0d, expected err=%0b wc=%0d",
                                 !load_done, word_count, l.err, l.wc);
                    end
                end
            end
        end
        err_prev = load_err;
        if (end_req && !end_ack) begin
            n_cmp++;
            if (fq.size() != 0) begin
                n_bad++;
                $display("FAIL pending_fetches: got %0d, expected 0", fq.size());
            end
            n_cmp++;
            if (lq.size() != 0) begin
                n_bad++;
                $display("FAIL pending_load_events: got %0d, expected 0", lq.size());
            end
            end_ack = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.req  = req;
        cq.push_back(c);
    endtask

    task automatic exp_load(input bit err, input int unsigned wc);
        lexp_t l;
        l.err = err;
        l.wc  = (AW+1)'(wc);
        lq.push_back(l);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit got;
        got = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rx_ready) got = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        if (!got) chk("rx_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit check);
        fexp_t f;
        f.data = data;
        f.check = check;
        fq.push_back(f);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            if (!load_busy) idle = 1'b1;
            else tick();
        end
        if (!idle) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        fetch_en   = 1'b0;
        fetch_addr = 32'h0;

        // Reset then idle
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_rx_ready",    64'(rx_ready),    64'd0);
        chk("rst_load_busy",   64'(load_busy),   64'd0);
        chk("rst_load_done",   64'(load_done),   64'd0);
        chk("rst_load_err",    64'(load_err),    64'd0);
        chk("rst_word_count",  64'(word_count),  64'd0);
        chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("rst_fetch_data",  64'(fetch_data),  64'd0);
        fetch(32'h0, 32'h0, 1'b0);

        // Basic load of two words
        exp_load(1'b0, 2);
        start_load();
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        wait_idle();
        chk("basic_word_count", 64'(word_count), 64'd2);
        fetch(32'h0000_0000, 32'h0000_0013, 1'b1);
        fetch(32'h0000_0004, 32'h0010_0093, 1'b1);
        fetch(32'h0000_8004, 32'h0010_0093, 1'b1);
        fetch(32'h0000_0001, 32'h0000_0013, 1'b1);
        fetch(32'hFFFF_8000, 32'h0000_0013, 1'b1);

        // Load with idle gaps between bytes
        exp_load(1'b0, 3);
        start_load();
        send_word(32'd3, 3);
        send_word(32'hDEAD_BEEF, 3);
        send_word(32'h0123_4567, 3);
        send_word(32'hA5A5_A5A5, 3);
        wait_idle();
        fetch(32'h0, 32'hDEAD_BEEF, 1'b1);
        fetch(32'h4, 32'h0123_4567, 1'b1);
        fetch(32'h8, 32'hA5A5_A5A5, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) begin
            chk("idle_rx_ready", 64'(rx_ready), 64'd0);
            tick();
        end
        rx_valid = 1'b0;
        chk("idle_load_busy", 64'(load_busy), 64'd0);

        // Zero-length load
        exp_load(1'b0, 0);
        start_load();
        send_word(32'd0, 0);
        chk("zero_load_done", 64'(load_done), 64'd1);
        chk("zero_word_count", 64'(word_count), 64'd0);
        wait_idle();
        fetch(32'h0, 32'hDEAD_BEEF, 1'b1);

        // Oversize header
        exp_load(1'b1, 0);
        start_load();
        send_word(32'(DEPTH + 1), 0);
        wait_idle();
        chk("oversize_load_err", 64'(load_err), 64'd1);
        chk("oversize_load_done", 64'(load_done), 64'd0);
        start_load();
        chk("restart_clears_err", 64'(load_err), 64'd0);
        chk("restart_busy", 64'(load_busy), 64'd1);
        exp_load(1'b0, 0);
        send_word(32'd0, 0);
        wait_idle();

        // fetch_en during DATA, then restart mid-DATA
        start_load();
        send_word(32'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        fetch_en   = 1'b1;
        fetch_addr = 32'h4;
        repeat (3) begin
            tick();
            chk("busy_fetch_valid", 64'(fetch_valid), 64'd0);
            chk("busy_fetch_hold", 64'(fetch_data), 64'hDEAD_BEEF);
        end
        fetch_en = 1'b0;
        exp_load(1'b0, 1);
        start_load();
        send_word(32'd1, 0);
        send_word(32'h1122_3344, 0);
        wait_idle();
        chk("restart_word_count", 64'(word_count), 64'd1);
        fetch(32'h0, 32'h1122_3344, 1'b1);
        fetch(32'h4, 32'h0123_4567, 1'b1);

        // Reset after five data bytes
        start_load();
        send_word(32'd3, 0);
        send_word(32'hCAFE_F00D, 0);
        chk("write_fetch_hold", 64'(fetch_data), 64'h0123_4567);
        send_byte(8'h77, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_load_busy", 64'(load_busy), 64'd0);
        chk("midrst_rx_ready", 64'(rx_ready), 64'd0);
        chk("midrst_word_count", 64'(word_count), 64'd0);
        fetch(32'h0, 32'hCAFE_F00D, 1'b1);
        fetch(32'h4, 32'h0123_4567, 1'b1);
        fetch(32'h8, 32'hA5A5_A5A5, 1'b1);

        repeat (3) tick();
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) tick();
        if (!end_ack) begin
            $display("FAIL monitor_end: got 0, expected 1");
            $fatal(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
